// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'b00,
    DIVU = 2'b01,
    REMU = 2'b10,
    RSVD = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Status word layout {n, z, c, v}
  localparam int STATUS_W = 4;
  localparam int STATUS_V = 0;
  localparam int STATUS_C = 1;
  localparam int STATUS_Z = 2;
  localparam int STATUS_N = 3;

endpackage

// File: rtl/ALU.sv
// Add/sub ALU with n/z/c/v status; for SUB the c flag is the borrow out.
module ALU
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]        a_i,
  input  logic [N-1:0]        b_i,
  input  logic [2:0]          op_i,
  output logic [N-1:0]        res_o,
  output logic [STATUS_W-1:0] status_o
);

  logic [N:0] sum;
  logic       ovf;

  // Opcodes other than SUB fall back to ADD
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    case (op_i)
      ALU_SUB: begin
        sum = {1'b0, a_i} - {1'b0, b_i};
        ovf = (a_i[N-1] != b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      default: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        ovf = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
    endcase
  end

  assign res_o              = sum[N-1:0];
  assign status_o[STATUS_N] = sum[N-1];
  assign status_o[STATUS_Z] = (sum[N-1:0] == '0);
  assign status_o[STATUS_C] = sum[N];
  assign status_o[STATUS_V] = ovf;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer: one shared add/sub ALU stepped once per
// cycle for N iterations between a valid/ready request and response port.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d, req_op_e;
  logic [CW-1:0] cnt_q, cnt_d;
  // Shared datapath: r = acc/rem, x = mcand/quo, y = mplier/dvsr
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;

  logic [N-1:0]        alu_a, alu_b, alu_res;
  logic [2:0]          alu_op;
  logic [STATUS_W-1:0] alu_st;
  logic                msb;
  logic [N-1:0]        sh;
  logic                unused_st;

  assign req_op_e  = muldiv_op_e'(req_op);
  assign msb       = r_q[N-1];
  assign sh        = {r_q[N-2:0], x_q[N-1]};
  assign unused_st = ^{alu_st[STATUS_N], alu_st[STATUS_Z], alu_st[STATUS_V]};

  ALU #(.N(N)) u_alu (
    .a_i     (alu_a),
    .b_i     (alu_b),
    .op_i    (alu_op),
    .res_o   (alu_res),
    .status_o(alu_st)
  );

  // ALU inputs are parked at zero/ADD outside CALC
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (state_q == CALC) begin
      if (op_q == MUL) begin
        alu_a = r_q;
        alu_b = x_q;
      end else begin
        alu_a  = sh;
        alu_b  = y_q;
        alu_op = ALU_SUB;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op_e;
          cnt_d   = '0;
          r_d     = '0;
          x_d     = req_a;
          y_d     = req_b;
          state_d = CALC;
          if (req_op_e == RSVD) begin
            state_d = DONE;
          end else if (req_op_e != MUL && req_b == '0) begin
            // Divide by zero: quotient all-ones, remainder is the dividend
            x_d     = '1;
            r_d     = req_a;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
        if (op_q == MUL) begin
          if (y_q[0]) r_d = alu_res;
          x_d = {x_q[N-2:0], 1'b0};
          y_d = {1'b0, y_q[N-1:1]};
        end else begin
          // A set msb means the true partial remainder exceeds N bits, so
          // the trial subtraction always fits
          x_d = {x_q[N-2:0], 1'b0};
          if (msb || !alu_st[STATUS_C]) begin
            r_d    = alu_res;
            x_d[0] = 1'b1;
          end else begin
            r_d = sh;
          end
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= MUL;
      cnt_q   <= '0;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);

  always_comb begin
    case (op_q)
      MUL:     rsp_data = r_q;
      DIVU:    rsp_data = x_q;
      REMU:    rsp_data = r_q;
      default: rsp_data = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed cases, back-pressure, mid-op
// reset and randomized traffic against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0] data;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  bit     rr_rand  = 1'b0;
  exp_t   q[$];
  bit     seen     = 1'b0;
  logic [N-1:0] prev_data;

  logic [1:0]   d_op [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
  logic [N-1:0] d_a  [9] = '{32'd7, 32'hFFFFFFFF, 32'd100, 32'd100, 32'h80000001,
                             32'h80000001, 32'd5, 32'd5, 32'd1234};
  logic [N-1:0] d_b  [9] = '{32'd6, 32'hFFFFFFFF, 32'd7, 32'd7, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'd0, 32'd0, 32'd99};

  muldiv_seq #(.N(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_model(input logic [1:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    logic [2*N-1:0] p;
    case (op)
      2'd0: begin p = {{N{1'b0}}, a} * {{N{1'b0}}, b}; return p[N-1:0]; end
      2'd1: return (b == 0) ? {N{1'b1}} : a / b;
      2'd2: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Drives one request until accepted; waits = negedges spent before acceptance
  task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int waits);
    exp_t e;
    bit   ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    waits = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready) begin
        e.data = ref_model(op, a, b);
        e.lat  = (op == 2'd3 || (op != 2'd0 && b == 0)) ? 1 : N + 1;
        e.acc  = cyc;
        q.push_back(e);
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
  endtask

  task automatic drain();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid) return;
    end
    chk("drain_timeout", 32'(q.size()), 32'(0));
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_data", rsp_data, 32'(0));
      seen = 1'b0;
    end else if (rsp_valid) begin
      chk("req_ready_in_done", 32'(req_ready), 32'(0));
      if (q.size() == 0) begin
        if (!seen) chk("unexpected_rsp", 32'(1), 32'(0));
        seen = 1'b1;
      end else begin
        if (!seen) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        else       chk("rsp_hold", rsp_data, prev_data);
        seen      = 1'b1;
        prev_data = rsp_data;
        if (rsp_ready) begin
          chk("rsp_data", rsp_data, q[0].data);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int w;
    logic [1:0]   op;
    logic [N-1:0] a, b;
    rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(1));

    for (int i = 0; i < 9; i++) issue(d_op[i], d_a[i], d_b[i], w);
    drain();

    // Back-pressure: response held while ignored request pulses arrive
    rsp_ready = 1'b0;
    issue(2'd0, 32'd11, 32'd13, w);
    begin
      bit got = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (rsp_valid) begin got = 1'b1; break; end
      end
      chk("bp_rsp_seen", 32'(got), 32'(1));
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      req_valid = k[0]; req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", 32'(rsp_valid), 32'(1));
    issue(2'd0, 32'd3, 32'd5, w);
    chk("bp_next_accept_wait", 32'(w), 32'(0));
    drain();

    // Reset in the middle of a divide aborts it silently
    issue(2'd1, 32'd1000, 32'd3, w);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'(1));
    issue(2'd0, 32'd3, 32'd3, w);
    drain();

    rr_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      issue(op, a, b, w);
    end
    rr_rand = 1'b0;
    #2 rsp_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
